mlp_feature_sequencer: RTL

- Producer/consumer front end for the combinational printed-MLP classifier.
- Accepts features one nibble at a time over a valid/ready stream and packs them into the classifier's flat input word.
- Holds that word stable for a programmable settle time, then samples the classifier's class index and presents it on a valid/ready result stream with a sample index.
- Sits between the serial sensor/test interface and the classifier core.

---
 rtl/mlp_feature_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mlp_feature_sequencer.sv
// mlp_feature_sequencer: packs nibble-wide features from a valid/ready stream
// into the flat input word of the combinational MLP classifier, holds the word
// for a settle time, then presents the sampled class index with a sample index.
// Optional macro MLP_SEQ_FAULT_CMP_EN adds a comparison against a golden
// classifier output, with a per-result mismatch flag and a saturating counter.
module mlp_feature_sequencer #(
  parameter int N_FEAT = 7,
  parameter int FEAT_W = 4,
  parameter int CLS_W  = 2,
  parameter int SETTLE = 4,
  parameter int IDX_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic [N_FEAT*FEAT_W-1:0] clf_inp,
  input  logic [CLS_W-1:0]         clf_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CLS_W-1:0]         m_class,
  output logic [IDX_W-1:0]         m_index,
  output logic                     err_len
`ifdef MLP_SEQ_FAULT_CMP_EN
  ,
  input  logic [CLS_W-1:0]         clf_out_ref,
  output logic                     m_mismatch,
  output logic [IDX_W-1:0]         mismatch_cnt
`endif
);

  localparam int              BC_W        = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT   = BC_W'(N_FEAT - 1);
  localparam logic [7:0]      SETTLE_INIT = 8'(SETTLE - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_HOLD} state_t;

  state_t           state;
  state_t           next_state;
  logic [BC_W-1:0]  beat_cnt;
  logic [7:0]       settle_cnt;
  logic [IDX_W-1:0] sample_cnt;
  logic             accept;
  logic             final_beat;
  logic             early_last;
  logic             capture;
  logic             result_taken;

  // Decode the stream and timing events shared by the FSM and the datapath.
  always_comb begin
    accept       = (state == ST_LOAD) && s_valid && s_ready;
    final_beat   = accept && (beat_cnt == LAST_BEAT);
    early_last   = accept && s_last && (beat_cnt != LAST_BEAT);
    capture      = (state == ST_SETTLE) && (settle_cnt == 8'd0);
    result_taken = (state == ST_HOLD) && m_valid && m_ready;
  end

  // Next-state logic: load a frame, wait for the classifier, hold the result.
  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD:   if (final_beat)   next_state = ST_SETTLE;
      ST_SETTLE: if (capture)      next_state = ST_HOLD;
      ST_HOLD:   if (result_taken) next_state = ST_LOAD;
      default:                     next_state = ST_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= next_state;
  end

  // Input side: beat counting, slot writes, framing errors and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      clf_inp  <= '0;
      s_ready  <= 1'b0;
      err_len  <= 1'b0;
    end else begin
      s_ready <= (next_state == ST_LOAD);
      err_len <= early_last || (final_beat && !s_last);
      if (accept) begin
        if (early_last) begin
          beat_cnt <= '0;
        end else begin
          clf_inp[beat_cnt*FEAT_W +: FEAT_W] <= s_data;
          beat_cnt <= final_beat ? '0 : beat_cnt + 1'b1;
        end
      end
    end
  end

  // Output side: settle countdown, class capture and result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      sample_cnt <= '0;
      m_valid    <= 1'b0;
      m_class    <= '0;
      m_index    <= '0;
    end else begin
      if (final_beat)
        settle_cnt <= SETTLE_INIT;
      else if ((state == ST_SETTLE) && !capture)
        settle_cnt <= settle_cnt - 8'd1;
      if (capture) begin
        m_class    <= clf_out;
        m_index    <= sample_cnt;
        m_valid    <= 1'b1;
        sample_cnt <= sample_cnt + 1'b1;
      end else if (result_taken) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef MLP_SEQ_FAULT_CMP_EN
  // Compare the classifier against the golden reference at each capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_mismatch   <= 1'b0;
      mismatch_cnt <= '0;
    end else if (capture) begin
      m_mismatch <= (clf_out != clf_out_ref);
      if ((clf_out != clf_out_ref) && (mismatch_cnt != '1))
        mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end
`else
  // Without the comparator there is no golden input and no mismatch state.
`endif

endmodule
